// File: rtl/write_channel_arbiter_pkg.sv
// Shared types and constants for the AXI write-channel arbiter.
package write_channel_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    ISSUE = 2'd2
  } arb_state_t;

  // Nine bits so a full 256-beat burst is representable.
  localparam int BEATS_WIDTH = 9;

endpackage

// File: rtl/write_channel_arbiter_rr_picker.sv
// Round-robin picker: first set bit of mask strictly after ptr, wrapping.
module rr_picker #(
  parameter int NUM_CHANNELS = 32,
  parameter int CH_ID_WIDTH  = 5
) (
  input  logic [NUM_CHANNELS-1:0] mask,
  input  logic [CH_ID_WIDTH-1:0]  ptr,
  output logic                    found,
  output logic [CH_ID_WIDTH-1:0]  idx
);

  logic [CH_ID_WIDTH-1:0] cand;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = NUM_CHANNELS; off >= 1; off--) begin
      cand = CH_ID_WIDTH'((int'(ptr) + off) % NUM_CHANNELS);
      if (mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/write_channel_arbiter.sv
// Shares one AXI write channel among DMA channels, issuing bursts round-robin.
module write_channel_arbiter
  import write_channel_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS = 32,
  parameter int CH_ID_WIDTH  = 5,
  parameter int LEN_WIDTH    = 16,
  parameter int MAX_BEATS    = 256
) (
  input  logic                    AXI_aclk,
  input  logic                    AXI_areset,
  input  logic                    load_valid,
  input  logic [CH_ID_WIDTH-1:0]  load_ch,
  input  logic [LEN_WIDTH-1:0]    load_len,
  output logic                    load_err,
  input  logic                    flush,
  input  logic                    arbWriteDone,
  output logic                    arbWriteValid,
  output logic [BEATS_WIDTH-1:0]  arbWriteBeats,
  output logic [CH_ID_WIDTH-1:0]  arbWriteChannel,
  output logic                    channelDone,
  output logic                    arbWriteTransactionsDone,
  output logic [NUM_CHANNELS-1:0] active_mask
);

  arb_state_t             state_reg;
  logic [CH_ID_WIDTH-1:0] ptr_reg;
  logic [CH_ID_WIDTH-1:0] picked_reg;
  logic [LEN_WIDTH-1:0]   rem_reg [NUM_CHANNELS];

  logic                   pick_found;
  logic [CH_ID_WIDTH-1:0] pick_idx;
  logic                   ch_in_range;
  logic                   ch_busy;
  logic                   load_accept;
  logic [LEN_WIDTH-1:0]   issue_rem;
  logic [LEN_WIDTH-1:0]   issue_beats;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_active
      assign active_mask[gi] = (rem_reg[gi] != '0);
    end
  endgenerate

  rr_picker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_ID_WIDTH  (CH_ID_WIDTH)
  ) u_picker (
    .mask  (active_mask),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A channel that is being picked or issued cannot be reloaded underneath us.
  always_comb begin
    ch_in_range = ({1'b0, load_ch} < (CH_ID_WIDTH + 1)'(NUM_CHANNELS));
    ch_busy     = 1'b0;
    if (state_reg == PICK && pick_found && pick_idx == load_ch)
      ch_busy = 1'b1;
    if (state_reg == ISSUE && picked_reg == load_ch)
      ch_busy = 1'b1;
    load_accept = load_valid && ch_in_range && !active_mask[load_ch] &&
                  (load_len != '0) && !ch_busy;
    issue_rem   = rem_reg[picked_reg];
    issue_beats = (issue_rem > LEN_WIDTH'(MAX_BEATS)) ? LEN_WIDTH'(MAX_BEATS) : issue_rem;
  end

  always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
    if (AXI_areset) begin
      state_reg                <= IDLE;
      ptr_reg                  <= CH_ID_WIDTH'(NUM_CHANNELS - 1);
      picked_reg               <= '0;
      arbWriteValid            <= 1'b0;
      arbWriteBeats            <= '0;
      arbWriteChannel          <= '0;
      channelDone              <= 1'b0;
      load_err                 <= 1'b0;
      arbWriteTransactionsDone <= 1'b1;
      for (int i = 0; i < NUM_CHANNELS; i++)
        rem_reg[i] <= '0;
    end else begin
      arbWriteValid            <= 1'b0;
      channelDone              <= 1'b0;
      load_err                 <= 1'b0;
      arbWriteTransactionsDone <= (active_mask == '0);
      if (flush) begin
        state_reg <= IDLE;
        for (int i = 0; i < NUM_CHANNELS; i++)
          rem_reg[i] <= '0;
      end else begin
        load_err <= load_valid && !load_accept;
        if (load_accept)
          rem_reg[load_ch] <= load_len;
        case (state_reg)
          IDLE: begin
            if (arbWriteDone)
              state_reg <= PICK;
          end
          PICK: begin
            if (pick_found) begin
              picked_reg <= pick_idx;
              state_reg  <= ISSUE;
            end else begin
              state_reg <= IDLE;
            end
          end
          ISSUE: begin
            arbWriteValid       <= 1'b1;
            arbWriteBeats       <= BEATS_WIDTH'(issue_beats);
            arbWriteChannel     <= picked_reg;
            channelDone         <= (issue_rem == issue_beats);
            rem_reg[picked_reg] <= issue_rem - issue_beats;
            ptr_reg             <= picked_reg;
            state_reg           <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_write_channel_arbiter.sv
// Bench for write_channel_arbiter: directed vector table, corner sequences, random vs model.
module tb_write_channel_arbiter;
  import write_channel_arbiter_pkg::*;

  localparam int N  = 32;
  localparam int CW = 5;
  localparam int LW = 16;
  localparam int MB = 256;

  logic            AXI_aclk = 1'b0;
  logic            AXI_areset;
  logic            load_valid;
  logic [CW-1:0]   load_ch;
  logic [LW-1:0]   load_len;
  logic            load_err;
  logic            flush;
  logic            arbWriteDone;
  logic            arbWriteValid;
  logic [BEATS_WIDTH-1:0] arbWriteBeats;
  logic [CW-1:0]   arbWriteChannel;
  logic            channelDone;
  logic            arbWriteTransactionsDone;
  logic [N-1:0]    active_mask;

  always #5 AXI_aclk = ~AXI_aclk;

  write_channel_arbiter #(
    .NUM_CHANNELS (N), .CH_ID_WIDTH (CW), .LEN_WIDTH (LW), .MAX_BEATS (MB)
  ) dut (
    .AXI_aclk                 (AXI_aclk),
    .AXI_areset               (AXI_areset),
    .load_valid               (load_valid),
    .load_ch                  (load_ch),
    .load_len                 (load_len),
    .load_err                 (load_err),
    .flush                    (flush),
    .arbWriteDone             (arbWriteDone),
    .arbWriteValid            (arbWriteValid),
    .arbWriteBeats            (arbWriteBeats),
    .arbWriteChannel          (arbWriteChannel),
    .channelDone              (channelDone),
    .arbWriteTransactionsDone (arbWriteTransactionsDone),
    .active_mask              (active_mask)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXI_aclk);
    #1;
  endtask

  task automatic do_load(input int ch, input int len, output logic err);
    load_valid = 1'b1;
    load_ch    = CW'(ch);
    load_len   = LW'(len);
    tick();
    load_valid = 1'b0;
    err        = load_err;
    $display("load ch=%0d len=%0d err=%0d mask=%h", ch, len, err, active_mask);
  endtask

  // Pulse arbWriteDone, then watch four cycles for the burst descriptor.
  task automatic do_req(output int nvalid, output int lat, output int ch, output int beats,
                        output int done);
    arbWriteDone = 1'b1;
    tick();
    arbWriteDone = 1'b0;
    nvalid = 0; lat = -1; ch = 0; beats = 0; done = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (arbWriteValid === 1'b1) begin
        nvalid++;
        if (lat < 0) begin
          lat = k; ch = int'(arbWriteChannel); beats = int'(arbWriteBeats);
          done = int'(channelDone);
        end
      end
    end
    $display("req valid=%0d lat=%0d ch=%0d beats=%0d done=%0d tdone=%0d",
             nvalid, lat, ch, beats, done, arbWriteTransactionsDone);
  endtask

  typedef struct {
    bit is_req;
    int ch;
    int len;
    bit exp_err;
    bit exp_active;
    bit exp_valid;
    int exp_ch;
    int exp_beats;
    bit exp_done;
    bit exp_tdone;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_load(int ch, int len, bit err, bit act);
    vec_t v = '{0, ch, len, err, act, 0, 0, 0, 0, 0};
    return v;
  endfunction

  function automatic vec_t mk_req(bit valid, int ch, int beats, bit done, bit tdone);
    vec_t v = '{1, 0, 0, 0, 0, valid, ch, beats, done, tdone};
    return v;
  endfunction

  // Reference model: remaining beats per channel and the last served channel.
  int rem_m [N];
  int ptr_m;

  function automatic int model_pick();
    for (int off = 1; off <= N; off++) begin
      if (rem_m[(ptr_m + off) % N] > 0) return (ptr_m + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = (rem_m[i] > 0);
    return m;
  endfunction

  function automatic bit model_idle();
    for (int i = 0; i < N; i++) if (rem_m[i] > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_reset();
    AXI_areset = 1'b1;
    tick();
    tick();
    AXI_areset = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic err;
    int nv, lat, ch, beats, done;

    AXI_areset = 1'b1; load_valid = 1'b0; load_ch = '0; load_len = '0;
    flush = 1'b0; arbWriteDone = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(arbWriteValid), 64'd0);
    chk("rst_beats", 64'(arbWriteBeats), 64'd0);
    chk("rst_channel", 64'(arbWriteChannel), 64'd0);
    chk("rst_done", 64'(channelDone), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);
    chk("rst_mask", 64'(active_mask), 64'd0);
    chk("rst_tdone", 64'(arbWriteTransactionsDone), 64'd1);
    AXI_areset = 1'b0;
    tick();

    // Directed vectors with hand-derived expectations.
    vecs.push_back(mk_load(3, 10, 0, 1));
    vecs.push_back(mk_req(1, 3, 10, 1, 1));
    vecs.push_back(mk_load(0, 600, 0, 1));
    vecs.push_back(mk_req(1, 0, 256, 0, 0));
    vecs.push_back(mk_req(1, 0, 256, 0, 0));
    vecs.push_back(mk_req(1, 0, 88, 1, 1));
    vecs.push_back(mk_load(1, 300, 0, 1));
    vecs.push_back(mk_load(5, 4, 0, 1));
    vecs.push_back(mk_load(30, 2, 0, 1));
    vecs.push_back(mk_req(1, 1, 256, 0, 0));
    vecs.push_back(mk_req(1, 5, 4, 1, 0));
    vecs.push_back(mk_req(1, 30, 2, 1, 0));
    vecs.push_back(mk_req(1, 1, 44, 1, 1));
    vecs.push_back(mk_req(0, 0, 0, 0, 1));
    vecs.push_back(mk_load(2, 20, 0, 1));
    vecs.push_back(mk_load(2, 7, 1, 1));
    vecs.push_back(mk_load(4, 0, 1, 0));
    vecs.push_back(mk_req(1, 2, 20, 1, 1));

    foreach (vecs[i]) begin
      if (!vecs[i].is_req) begin
        do_load(vecs[i].ch, vecs[i].len, err);
        chk($sformatf("vec%0d_load_err", i), 64'(err), 64'(vecs[i].exp_err));
        chk($sformatf("vec%0d_active", i), 64'(active_mask[vecs[i].ch]), 64'(vecs[i].exp_active));
      end else begin
        do_req(nv, lat, ch, beats, done);
        chk($sformatf("vec%0d_nvalid", i), 64'(nv), 64'(vecs[i].exp_valid ? 1 : 0));
        if (vecs[i].exp_valid) begin
          chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
          chk($sformatf("vec%0d_channel", i), 64'(ch), 64'(vecs[i].exp_ch));
          chk($sformatf("vec%0d_beats", i), 64'(beats), 64'(vecs[i].exp_beats));
          chk($sformatf("vec%0d_chdone", i), 64'(done), 64'(vecs[i].exp_done));
        end
        chk($sformatf("vec%0d_tdone", i), 64'(arbWriteTransactionsDone), 64'(vecs[i].exp_tdone));
      end
    end

    // arbWriteTransactionsDone rises exactly one cycle after the final channelDone.
    do_load(9, 1, err);
    arbWriteDone = 1'b1; tick(); arbWriteDone = 1'b0;
    tick();
    tick();
    chk("tdone_seq_valid", 64'(arbWriteValid), 64'd1);
    chk("tdone_seq_chdone", 64'(channelDone), 64'd1);
    chk("tdone_seq_low", 64'(arbWriteTransactionsDone), 64'd0);
    tick();
    chk("tdone_seq_high", 64'(arbWriteTransactionsDone), 64'd1);
    chk("tdone_seq_pulse", 64'(arbWriteValid), 64'd0);

    // Loads while a request is in flight: other channel accepted, picked channel rejected.
    do_load(6, 5, err);
    arbWriteDone = 1'b1; tick(); arbWriteDone = 1'b0;
    load_valid = 1'b1; load_ch = 5'd8; load_len = 16'd3;
    tick();
    chk("pick_other_err", 64'(load_err), 64'd0);
    load_ch = 5'd6; load_len = 16'd9;
    tick();
    load_valid = 1'b0;
    chk("issue_same_err", 64'(load_err), 64'd1);
    chk("inflight_valid", 64'(arbWriteValid), 64'd1);
    chk("inflight_channel", 64'(arbWriteChannel), 64'd6);
    chk("inflight_beats", 64'(arbWriteBeats), 64'd5);
    tick();
    do_req(nv, lat, ch, beats, done);
    chk("late_load_channel", 64'(ch), 64'd8);
    chk("late_load_beats", 64'(beats), 64'd3);
    do_load(6, 4, err);
    arbWriteDone = 1'b1; tick(); arbWriteDone = 1'b0;
    load_valid = 1'b1; load_ch = 5'd6; load_len = 16'd9;
    tick();
    load_valid = 1'b0;
    chk("pick_same_err", 64'(load_err), 64'd1);
    tick();
    chk("pick_same_beats", 64'(arbWriteBeats), 64'd4);
    tick();
    tick();

    // flush while the FSM is in PICK.
    do_load(7, 500, err);
    arbWriteDone = 1'b1; tick(); arbWriteDone = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_mask", 64'(active_mask), 64'd0);
    tick();
    chk("flush_no_valid", 64'(arbWriteValid), 64'd0);
    tick();
    chk("flush_tdone", 64'(arbWriteTransactionsDone), 64'd1);
    chk("flush_no_valid2", 64'(arbWriteValid), 64'd0);

    // Asynchronous reset asserted while the FSM is in ISSUE.
    do_load(7, 500, err);
    do_load(12, 5, err);
    tick();
    arbWriteDone = 1'b1; tick(); arbWriteDone = 1'b0;
    tick();
    AXI_areset = 1'b1;
    #1;
    chk("arst_valid", 64'(arbWriteValid), 64'd0);
    chk("arst_beats", 64'(arbWriteBeats), 64'd0);
    chk("arst_mask", 64'(active_mask), 64'd0);
    chk("arst_tdone", 64'(arbWriteTransactionsDone), 64'd1);
    chk("arst_channel", 64'(arbWriteChannel), 64'd0);
    tick();
    chk("arst_hold_valid", 64'(arbWriteValid), 64'd0);
    AXI_areset = 1'b0;
    tick();
    do_load(5, 3, err);
    do_load(0, 3, err);
    do_req(nv, lat, ch, beats, done);
    chk("ptr_reset_channel", 64'(ch), 64'd0);

    // Randomized operations against the reference model.
    apply_reset();
    for (int i = 0; i < N; i++) rem_m[i] = 0;
    ptr_m = N - 1;
    for (int t = 0; t < 250; t++) begin
      int r = $urandom_range(0, 99);
      if (r < 55) begin
        int rch  = $urandom_range(0, N - 1);
        int rlen = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 700);
        bit eerr = (rlen == 0) || (rem_m[rch] > 0);
        do_load(rch, rlen, err);
        if (!eerr) rem_m[rch] = rlen;
        chk($sformatf("rnd%0d_load_err", t), 64'(err), 64'(eerr));
        chk($sformatf("rnd%0d_mask", t), 64'(active_mask), 64'(model_mask()));
      end else if (r < 58) begin
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < N; i++) rem_m[i] = 0;
        $display("flush mask=%h", active_mask);
        chk($sformatf("rnd%0d_flush_mask", t), 64'(active_mask), 64'd0);
      end else begin
        int pc = model_pick();
        do_req(nv, lat, ch, beats, done);
        chk($sformatf("rnd%0d_nvalid", t), 64'(nv), 64'(pc >= 0 ? 1 : 0));
        if (pc >= 0) begin
          int eb = (rem_m[pc] > MB) ? MB : rem_m[pc];
          rem_m[pc] -= eb;
          ptr_m = pc;
          chk($sformatf("rnd%0d_latency", t), 64'(lat), 64'd2);
          chk($sformatf("rnd%0d_channel", t), 64'(ch), 64'(pc));
          chk($sformatf("rnd%0d_beats", t), 64'(beats), 64'(eb));
          chk($sformatf("rnd%0d_chdone", t), 64'(done), 64'(rem_m[pc] == 0 ? 1 : 0));
        end
        chk($sformatf("rnd%0d_tdone", t), 64'(arbWriteTransactionsDone), 64'(model_idle()));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
